capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
Frame-level sequencer for the camera capture path. It enables the pixel capture stage once sensor configuration is done, discards warm-up frames, and gates frame-RAM writes. It manages ping-pong bank selection between the write bank (camera) and the read bank (display/filter), and applies run/freeze/snapshot and filter-select changes only at frame boundaries. It also validates every frame by pixel count.

Parameters:
SKIP_FRAMES, 10, complete frames discarded after config_done before writing starts (0 = none)
FRAME_PIXELS, 307200, data_en pulses in a good frame (640x480)
CNT_W, 20, pixel counter width; saturates at all-ones

Ports:
pclk  in  1  pixel clock, single clock domain
rst_n  in  1  asynchronous active-low reset
config_done  in  1  sensor register configuration complete (level)
vsync  in  1  camera vsync, high during active frame
pix_valid  in  1  data_en from capture stage, one pulse per assembled pixel
run_req  in  1  single-cycle pulse: continuous capture
freeze_req  in  1  single-cycle pulse: stop writing, hold image
snap_req  in  1  single-cycle pulse: capture exactly one good frame then freeze
filter_req  in  3  requested filter select (level)
cap_enable  out  1  registered; drives capture stage config_done input
ram_we  out  1  combinational frame-RAM write enable
wr_bank  out  1  bank bit appended to capture write address
rd_bank  out  1  bank bit for display read address
filter_sel  out  3  frame-stable filter select
frame_cnt  out  8  good frames written, wraps 255->0
frame_err  out  1  one-cycle pulse: bad pixel count
snap_done  out  1  one-cycle pulse: snapshot frame committed

Behaviour:
- Reset values: state IDLE, cap_enable 0, wr_bank 0, rd_bank 1, filter_sel 0, frame_cnt 0, frame_err 0, snap_done 0, frame_active 0, pending mode NONE, pixel count 0. ram_we is therefore 0.
- Edge detect: vs_d <= {vs_d[0], vsync}. rise = (vs_d==01), fall = (vs_d==10). All boundary actions register on the edge where rise/fall is true.
- States: IDLE, SKIP, RUN, FREEZE, SNAP.
- IDLE: cap_enable 0.
  - config_done high -> SKIP with skip_cnt = SKIP_FRAMES, cap_enable 1.
  - If SKIP_FRAMES == 0, go -> RUN directly.
- Rise (state != IDLE): set frame_active 1 and clear pixel count. filter_sel <= filter_req sampled on that cycle. Apply pending mode, then clear pending:
  - FREEZE pending from RUN/SNAP -> FREEZE.
  - RUN pending from FREEZE -> RUN.
  - SNAP pending from FREEZE/RUN -> SNAP.
- Pixel count increments on pix_valid while frame_active. A good frame is count == FRAME_PIXELS exactly.
- ram_we = pix_valid & frame_active & (state==RUN | state==SNAP). SKIP and FREEZE never write.
- Fall with frame_active: clear frame_active, then act by state:
  - SKIP: decrement skip_cnt regardless of count; when it reaches 0, go -> RUN.
  - RUN, good frame: rd_bank <= wr_bank, wr_bank <= ~wr_bank, frame_cnt++.
  - RUN, bad frame: frame_err pulse; banks and frame_cnt unchanged, so the same bank is rewritten.
  - SNAP, good frame: swap as in RUN, frame_cnt++, snap_done pulse, go -> FREEZE.
  - SNAP, bad frame: frame_err pulse; stay in SNAP and retry the next frame.
- Fall without frame_active (partial frame after enable): ignored.
- Requests accepted only in RUN, FREEZE, SNAP; ignored in IDLE and SKIP.
  - Simultaneous request priority: freeze > snap > run.
  - A newer request overwrites the pending one.
  - A request equal to the current state clears pending.
- config_done low in any state -> IDLE on the next edge: cap_enable 0, frame_active 0, pending cleared. Banks, frame_cnt and filter_sel hold.
- frame_err and snap_done are registered; they are high for exactly the one cycle after the fall edge.

Test Plan:
- Startup (FRAME_PIXELS=16, SKIP_FRAMES=2): config_done=1, three 16-pixel frames -> ram_we 0 during frames 1-2. Frame 3 gives 16 ram_we pulses; after its fall wr_bank=1, rd_bank=0, frame_cnt=1.
- Bad frames in RUN: 15 pixels, then 17 pixels -> frame_err pulses twice; wr_bank/rd_bank/frame_cnt unchanged. A following 16-pixel frame swaps banks and sets frame_cnt+1.
- freeze_req mid-frame with run_req in the same cycle -> the current frame completes and swaps. Next frame: state FREEZE, zero ram_we pulses, banks held.
- snap_req in FREEZE: first frame 15 pixels -> frame_err and stay SNAP. Second frame 16 pixels -> swap, snap_done pulse, back to FREEZE.
- filter_req changed to 3'd5 mid-frame -> filter_sel holds its old value until the rise-detect edge of the next frame, then reads 5.
- config_done dropped mid-frame -> cap_enable 0 and ram_we 0 on the next cycle, state IDLE. Re-asserting config_done -> two frames skipped again before writes resume; banks are preserved.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: frame-level sequencer for the camera capture path.
// Enables the capture stage after sensor configuration, discards warm-up
// frames, gates frame-RAM writes, swaps ping-pong banks on good frames and
// applies run/freeze/snapshot and filter changes only at frame boundaries.
module capture_ctrl #(
    parameter int SKIP_FRAMES  = 10,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 20
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       config_done,
    input  logic       vsync,
    input  logic       pix_valid,
    input  logic       run_req,
    input  logic       freeze_req,
    input  logic       snap_req,
    input  logic [2:0] filter_req,
    output logic       cap_enable,
    output logic       ram_we,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic [2:0] filter_sel,
    output logic [7:0] frame_cnt,
    output logic       frame_err,
    output logic       snap_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SKIP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FREEZE = 3'd3,
        ST_SNAP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE   = 2'd0,
        PEND_RUN    = 2'd1,
        PEND_FREEZE = 2'd2,
        PEND_SNAP   = 2'd3
    } pend_t;

    localparam int                SKIP_W    = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0]  GOOD_CNT  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_nxt_s;
    pend_t             pend_r;
    pend_t             req_s;
    logic              req_valid_s;
    logic              req_same_s;
    logic              req_ok_s;
    logic [1:0]        vs_d_r;
    logic              rise_s;
    logic              fall_s;
    logic              frame_active_r;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic [SKIP_W-1:0] skip_cnt_r;
    logic              good_s;
    logic              cap_enable_r;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [2:0]        filter_sel_r;
    logic [7:0]        frame_cnt_r;
    logic              frame_err_r;
    logic              snap_done_r;
    logic              ram_we_s;

    assign rise_s = (vs_d_r == 2'b01);
    assign fall_s = (vs_d_r == 2'b10);
    assign good_s = (pix_cnt_r == GOOD_CNT);

    // State register, vsync edge-detect history and capture-stage enable
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            vs_d_r       <= 2'b00;
            cap_enable_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            vs_d_r       <= {vs_d_r[0], vsync};
            cap_enable_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state logic: config loss dominates, mode changes only at boundaries
    always_comb begin
        state_nxt_s = state_r;
        if (!config_done) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = (SKIP_FRAMES == 0) ? ST_RUN : ST_SKIP;
                end
                ST_SKIP: begin
                    if (fall_s && frame_active_r && (skip_cnt_r == SKIP_W'(1))) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_SKIP;
                    end
                end
                ST_RUN: begin
                    if (rise_s && (pend_r == PEND_FREEZE)) begin
                        state_nxt_s = ST_FREEZE;
                    end else if (rise_s && (pend_r == PEND_SNAP)) begin
                        state_nxt_s = ST_SNAP;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FREEZE: begin
                    if (rise_s && (pend_r == PEND_RUN)) begin
                        state_nxt_s = ST_RUN;
                    end else if (rise_s && (pend_r == PEND_SNAP)) begin
                        state_nxt_s = ST_SNAP;
                    end else begin
                        state_nxt_s = ST_FREEZE;
                    end
                end
                ST_SNAP: begin
                    if (rise_s && (pend_r == PEND_FREEZE)) begin
                        state_nxt_s = ST_FREEZE;
                    end else if (fall_s && frame_active_r && good_s) begin
                        state_nxt_s = ST_FREEZE;
                    end else begin
                        state_nxt_s = ST_SNAP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Request decode: freeze beats snap beats run; same-as-current cancels
    always_comb begin
        req_s       = PEND_NONE;
        req_valid_s = 1'b0;
        if (freeze_req) begin
            req_s       = PEND_FREEZE;
            req_valid_s = 1'b1;
        end else if (snap_req) begin
            req_s       = PEND_SNAP;
            req_valid_s = 1'b1;
        end else if (run_req) begin
            req_s       = PEND_RUN;
            req_valid_s = 1'b1;
        end else begin
            req_s       = PEND_NONE;
            req_valid_s = 1'b0;
        end
        req_ok_s   = (state_r == ST_RUN) || (state_r == ST_FREEZE) || (state_r == ST_SNAP);
        req_same_s = ((req_s == PEND_RUN)    && (state_r == ST_RUN))    ||
                     ((req_s == PEND_FREEZE) && (state_r == ST_FREEZE)) ||
                     ((req_s == PEND_SNAP)   && (state_r == ST_SNAP));
    end

    // Pending mode register: consumed at frame start, cleared on config loss
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= PEND_NONE;
        end else if (!config_done) begin
            pend_r <= PEND_NONE;
        end else if (req_valid_s && req_ok_s) begin
            pend_r <= req_same_s ? PEND_NONE : req_s;
        end else if (rise_s || (state_r == ST_IDLE)) begin
            pend_r <= PEND_NONE;
        end
    end

    // Frame tracking, pixel counting, bank swap and boundary status pulses
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_active_r <= 1'b0;
            pix_cnt_r      <= {CNT_W{1'b0}};
            skip_cnt_r     <= {SKIP_W{1'b0}};
            wr_bank_r      <= 1'b0;
            rd_bank_r      <= 1'b1;
            filter_sel_r   <= 3'd0;
            frame_cnt_r    <= 8'd0;
            frame_err_r    <= 1'b0;
            snap_done_r    <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            snap_done_r <= 1'b0;
            if (!config_done) begin
                frame_active_r <= 1'b0;
            end else if (state_r == ST_IDLE) begin
                frame_active_r <= 1'b0;
                skip_cnt_r     <= SKIP_INIT;
            end else if (rise_s) begin
                frame_active_r <= 1'b1;
                pix_cnt_r      <= {CNT_W{1'b0}};
                filter_sel_r   <= filter_req;
            end else if (fall_s && frame_active_r) begin
                frame_active_r <= 1'b0;
                case (state_r)
                    ST_SKIP: begin
                        skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
                    end
                    ST_RUN, ST_SNAP: begin
                        if (good_s) begin
                            rd_bank_r   <= wr_bank_r;
                            wr_bank_r   <= ~wr_bank_r;
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                            snap_done_r <= (state_r == ST_SNAP);
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        frame_active_r <= 1'b0;
                    end
                endcase
            end else if (pix_valid && frame_active_r && (pix_cnt_r != CNT_MAX)) begin
                pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
        end
    end

    // Frame-RAM write enable: only while writing states own an active frame
    always_comb begin
        if ((state_r == ST_RUN) || (state_r == ST_SNAP)) begin
            ram_we_s = pix_valid & frame_active_r;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    assign cap_enable = cap_enable_r;
    assign ram_we     = ram_we_s;
    assign wr_bank    = wr_bank_r;
    assign rd_bank    = rd_bank_r;
    assign filter_sel = filter_sel_r;
    assign frame_cnt  = frame_cnt_r;
    assign frame_err  = frame_err_r;
    assign snap_done  = snap_done_r;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 16-pixel frame and two skip frames.
module tb_capture_ctrl;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       config_done;
    logic       vsync;
    logic       pix_valid;
    logic       run_req;
    logic       freeze_req;
    logic       snap_req;
    logic [2:0] filter_req;
    logic       cap_enable;
    logic       ram_we;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] filter_sel;
    logic [7:0] frame_cnt;
    logic       frame_err;
    logic       snap_done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Results gathered by run_frame
    int we_cnt;
    int err_cnt;
    int snp_cnt;
    int fs_early;
    int fs_late;
    int drop_cap;
    int drop_we;

    capture_ctrl #(
        .SKIP_FRAMES  (2),
        .FRAME_PIXELS (16),
        .CNT_W        (20)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .config_done (config_done),
        .vsync       (vsync),
        .pix_valid   (pix_valid),
        .run_req     (run_req),
        .freeze_req  (freeze_req),
        .snap_req    (snap_req),
        .filter_req  (filter_req),
        .cap_enable  (cap_enable),
        .ram_we      (ram_we),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .filter_sel  (filter_sel),
        .frame_cnt   (frame_cnt),
        .frame_err   (frame_err),
        .snap_done   (snap_done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One vsync frame of npix pixels; act at pixel npix/2:
    // 1 = freeze+run pulse, 2 = filter_req <= 5, 3 = drop config_done
    task automatic run_frame(input int npix, input int act);
        we_cnt  = 0;
        err_cnt = 0;
        snp_cnt = 0;
        vsync   = 1'b1;
        @(negedge pclk);
        fs_early = int'(filter_sel);
        @(negedge pclk);
        fs_late = int'(filter_sel);
        repeat (2) @(negedge pclk);
        for (int i = 0; i < npix; i++) begin
            if (i == npix / 2) begin
                if (act == 1) begin
                    freeze_req = 1'b1;
                    run_req    = 1'b1;
                    @(negedge pclk);
                    freeze_req = 1'b0;
                    run_req    = 1'b0;
                end else if (act == 2) begin
                    filter_req = 3'd5;
                end else if (act == 3) begin
                    config_done = 1'b0;
                    @(negedge pclk);
                    pix_valid = 1'b1;
                    #1;
                    drop_cap = int'(cap_enable);
                    drop_we  = int'(ram_we);
                    @(negedge pclk);
                    pix_valid = 1'b0;
                    @(negedge pclk);
                end
            end
            pix_valid = 1'b1;
            #1;
            if (ram_we) we_cnt++;
            @(negedge pclk);
            pix_valid = 1'b0;
            @(negedge pclk);
        end
        repeat (2) @(negedge pclk);
        vsync = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            if (frame_err) err_cnt++;
            if (snap_done) snp_cnt++;
        end
    endtask

    task automatic pulse_req(input int which);
        if (which == 0) run_req = 1'b1;
        else if (which == 1) freeze_req = 1'b1;
        else snap_req = 1'b1;
        @(negedge pclk);
        run_req    = 1'b0;
        freeze_req = 1'b0;
        snap_req   = 1'b0;
        @(negedge pclk);
    endtask

    task automatic check_banks(input string tag, input int w, input int r, input int c);
        check({tag, "_wr_bank"}, int'(wr_bank), w);
        check({tag, "_rd_bank"}, int'(rd_bank), r);
        check({tag, "_frame_cnt"}, int'(frame_cnt), c);
    endtask

    initial begin
        rst_n       = 1'b0;
        config_done = 1'b0;
        vsync       = 1'b0;
        pix_valid   = 1'b0;
        run_req     = 1'b0;
        freeze_req  = 1'b0;
        snap_req    = 1'b0;
        filter_req  = 3'd0;
        drop_cap    = -1;
        drop_we     = -1;
        repeat (3) @(negedge pclk);
        check("rst_cap_enable", int'(cap_enable), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check_banks("rst", 0, 1, 0);
        check("rst_filter_sel", int'(filter_sel), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_snap_done", int'(snap_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge pclk);
        check("idle_cap_enable", int'(cap_enable), 0);

        // Startup: two frames discarded, third written
        config_done = 1'b1;
        repeat (2) @(negedge pclk);
        check("cfg_cap_enable", int'(cap_enable), 1);
        run_frame(16, 0);
        check("skip1_we", we_cnt, 0);
        run_frame(16, 0);
        check("skip2_we", we_cnt, 0);
        check_banks("skip2", 0, 1, 0);
        run_frame(16, 0);
        check("run1_we", we_cnt, 16);
        check("run1_err", err_cnt, 0);
        check_banks("run1", 1, 0, 1);

        // Bad frames in RUN rewrite the same bank
        run_frame(15, 0);
        check("short_we", we_cnt, 15);
        check("short_err", err_cnt, 1);
        run_frame(17, 0);
        check("long_err", err_cnt, 1);
        check_banks("bad", 1, 0, 1);
        run_frame(16, 0);
        check("good_err", err_cnt, 0);
        check_banks("good", 0, 1, 2);

        // Freeze and run together mid-frame: freeze wins at next boundary
        run_frame(16, 1);
        check("frz_cur_we", we_cnt, 16);
        check_banks("frz_cur", 1, 0, 3);
        run_frame(16, 0);
        check("frz_we", we_cnt, 0);
        check("frz_err", err_cnt, 0);
        check_banks("frz", 1, 0, 3);

        // Snapshot: bad frame retries, good frame commits then freezes
        pulse_req(2);
        run_frame(15, 0);
        check("snap_bad_we", we_cnt, 15);
        check("snap_bad_err", err_cnt, 1);
        check("snap_bad_done", snp_cnt, 0);
        check_banks("snap_bad", 1, 0, 3);
        run_frame(16, 0);
        check("snap_ok_we", we_cnt, 16);
        check("snap_ok_err", err_cnt, 0);
        check("snap_ok_done", snp_cnt, 1);
        check_banks("snap_ok", 0, 1, 4);
        run_frame(16, 0);
        check("post_snap_we", we_cnt, 0);

        // Filter change mid-frame takes effect at next frame start
        run_frame(16, 2);
        check("flt_mid_early", fs_early, 0);
        check("flt_hold", int'(filter_sel), 0);
        pulse_req(0);
        run_frame(16, 0);
        check("flt_next_early", fs_early, 0);
        check("flt_next_late", fs_late, 5);
        check("resume_we", we_cnt, 16);
        check_banks("resume", 1, 0, 5);

        // Config loss mid-frame, then restart with skips; banks preserved
        run_frame(16, 3);
        check("drop_cap_enable", drop_cap, 0);
        check("drop_ram_we", drop_we, 0);
        check("drop_we_total", we_cnt, 8);
        check("drop_err", err_cnt, 0);
        check("drop_cap_after", int'(cap_enable), 0);
        check("drop_filter", int'(filter_sel), 5);
        check_banks("drop", 1, 0, 5);
        config_done = 1'b1;
        repeat (2) @(negedge pclk);
        check("recfg_cap_enable", int'(cap_enable), 1);
        run_frame(16, 0);
        check("reskip1_we", we_cnt, 0);
        run_frame(16, 0);
        check("reskip2_we", we_cnt, 0);
        run_frame(16, 0);
        check("rerun_we", we_cnt, 16);
        check_banks("rerun", 0, 1, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
